fp_mul_lane_pipe: RTL and testbench

- Multi-lane, pipelined IEEE-754 significand/exponent multiplier front-end for the Kulisch accumulator datapath.
- Generalises the single-lane combinational FP16 multiplier in four ways:
  - parametrised format (FP16, BF16, ...);
  - LANES parallel products;
  - configurable pipeline depth with valid/ready backpressure;
  - per-lane special-value classification and sticky exception flags.
- Output is a resolved unsigned significand product plus unbiased exponent and sign, consumed by the accumulator's shift/add stage.

---
 rtl/fp_mul_lane_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fp_mul_lane_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_lane_pipe.sv
// Multi-lane pipelined FP significand/exponent multiplier feeding the Kulisch accumulator.
// Each lane yields an exact significand product, unbiased exponent, sign and special-value flags.
module fp_mul_lane_pipe #(
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    localparam int DWIDTH = 1 + EWIDTH + MWIDTH,
    localparam int BIAS   = (1 << (EWIDTH - 1)) - 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [LANES*DWIDTH-1:0]        in_a_i,
    input  logic [LANES*DWIDTH-1:0]        in_b_i,
    input  logic [LANES-1:0]               in_mask_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [LANES*(2*MWIDTH+2)-1:0]  out_prod_o,
    output logic [LANES*(EWIDTH+1)-1:0]    out_exp_o,
    output logic [LANES-1:0]               out_sign_o,
    output logic [LANES-1:0]               out_zero_o,
    output logic [LANES-1:0]               out_inf_o,
    output logic [LANES-1:0]               out_nan_o,
    output logic                           sticky_nan_o,
    output logic                           sticky_inf_o,
    input  logic                           clr_sticky_i
);

    localparam int PW  = 2 * MWIDTH + 2;
    localparam int EXW = EWIDTH + 1;
    localparam int SW  = MWIDTH + 1;

    logic [LANES*PW-1:0]  prod_c;
    logic [LANES*EXW-1:0] exp_c;
    logic [LANES-1:0]     sign_c, zero_c, inf_c, nan_c;

    always_comb begin
        logic [EWIDTH-1:0] ea, eb;
        logic [MWIDTH-1:0] ma, mb;
        logic [SW-1:0]     sig_a, sig_b;
        logic [EXW-1:0]    ue_a, ue_b;
        logic [PW-1:0]     p;
        logic              na, nb, ia, ib, za, zb, nan, inf;
        prod_c = '0;
        exp_c  = '0;
        sign_c = '0;
        zero_c = '0;
        inf_c  = '0;
        nan_c  = '0;
        ea = '0; eb = '0; ma = '0; mb = '0;
        sig_a = '0; sig_b = '0; ue_a = '0; ue_b = '0; p = '0;
        na = 1'b0; nb = 1'b0; ia = 1'b0; ib = 1'b0; za = 1'b0; zb = 1'b0;
        nan = 1'b0; inf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            ea = in_a_i[l*DWIDTH+MWIDTH +: EWIDTH];
            eb = in_b_i[l*DWIDTH+MWIDTH +: EWIDTH];
            ma = in_a_i[l*DWIDTH +: MWIDTH];
            mb = in_b_i[l*DWIDTH +: MWIDTH];
            sig_a = {|ea, ma};
            sig_b = {|eb, mb};
            // Subnormals share the exponent of the smallest normal.
            ue_a = (ea != '0) ? ({1'b0, ea} - EXW'(BIAS)) : EXW'(1 - BIAS);
            ue_b = (eb != '0) ? ({1'b0, eb} - EXW'(BIAS)) : EXW'(1 - BIAS);
            p    = PW'(sig_a) * PW'(sig_b);
            na   = (&ea) & (|ma);
            nb   = (&eb) & (|mb);
            ia   = (&ea) & ~(|ma);
            ib   = (&eb) & ~(|mb);
            za   = ~(|ea) & ~(|ma);
            zb   = ~(|eb) & ~(|mb);
            nan  = na | nb | (ia & zb) | (ib & za);
            inf  = (ia | ib) & ~nan;
            if (in_mask_i[l]) begin
                sign_c[l] = in_a_i[l*DWIDTH+DWIDTH-1] ^ in_b_i[l*DWIDTH+DWIDTH-1];
                nan_c[l]  = nan;
                inf_c[l]  = inf;
                if (!(nan || inf)) begin
                    prod_c[l*PW +: PW]   = p;
                    exp_c[l*EXW +: EXW]  = ue_a + ue_b;
                    zero_c[l]            = (p == '0);
                end
            end
        end
    end

    logic [STAGES-1:0]    vld_q, vld_d, ld;
    logic [LANES*PW-1:0]  prod_q [STAGES];
    logic [LANES*PW-1:0]  prod_d [STAGES];
    logic [LANES*EXW-1:0] exp_q  [STAGES];
    logic [LANES*EXW-1:0] exp_d  [STAGES];
    logic [LANES-1:0]     sign_q [STAGES];
    logic [LANES-1:0]     sign_d [STAGES];
    logic [LANES-1:0]     zero_q [STAGES];
    logic [LANES-1:0]     zero_d [STAGES];
    logic [LANES-1:0]     inf_q  [STAGES];
    logic [LANES-1:0]     inf_d  [STAGES];
    logic [LANES-1:0]     nan_q  [STAGES];
    logic [LANES-1:0]     nan_d  [STAGES];
    logic                 sticky_nan_q, sticky_nan_d;
    logic                 sticky_inf_q, sticky_inf_d;
    logic                 xfer;

    // A stage can load if the output drains or any stage at or after it has a hole.
    always_comb begin
        ld = '0;
        for (int s = 0; s < STAGES; s++) begin
            ld[s] = out_ready_i;
            for (int j = s; j < STAGES; j++) begin
                if (!vld_q[j]) ld[s] = 1'b1;
            end
        end
    end

    always_comb begin
        vld_d     = '0;
        vld_d[0]  = in_valid_i;
        prod_d[0] = prod_c;
        exp_d[0]  = exp_c;
        sign_d[0] = sign_c;
        zero_d[0] = zero_c;
        inf_d[0]  = inf_c;
        nan_d[0]  = nan_c;
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s]  = vld_q[s-1];
            prod_d[s] = prod_q[s-1];
            exp_d[s]  = exp_q[s-1];
            sign_d[s] = sign_q[s-1];
            zero_d[s] = zero_q[s-1];
            inf_d[s]  = inf_q[s-1];
            nan_d[s]  = nan_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s] <= '0;
                exp_q[s]  <= '0;
                sign_q[s] <= '0;
                zero_q[s] <= '0;
                inf_q[s]  <= '0;
                nan_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    vld_q[s] <= vld_d[s];
                    // Payload only moves with a valid bundle, so a stalled output stays put.
                    if (vld_d[s]) begin
                        prod_q[s] <= prod_d[s];
                        exp_q[s]  <= exp_d[s];
                        sign_q[s] <= sign_d[s];
                        zero_q[s] <= zero_d[s];
                        inf_q[s]  <= inf_d[s];
                        nan_q[s]  <= nan_d[s];
                    end
                end
            end
        end
    end

    assign xfer         = vld_q[STAGES-1] & out_ready_i;
    assign sticky_nan_d = clr_sticky_i ? 1'b0 : (sticky_nan_q | (xfer & (|nan_q[STAGES-1])));
    assign sticky_inf_d = clr_sticky_i ? 1'b0 : (sticky_inf_q | (xfer & (|inf_q[STAGES-1])));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_nan_q <= 1'b0;
            sticky_inf_q <= 1'b0;
        end else begin
            sticky_nan_q <= sticky_nan_d;
            sticky_inf_q <= sticky_inf_d;
        end
    end

    assign in_ready_o   = ld[0];
    assign out_valid_o  = vld_q[STAGES-1];
    assign out_prod_o   = prod_q[STAGES-1];
    assign out_exp_o    = exp_q[STAGES-1];
    assign out_sign_o   = sign_q[STAGES-1];
    assign out_zero_o   = zero_q[STAGES-1];
    assign out_inf_o    = inf_q[STAGES-1];
    assign out_nan_o    = nan_q[STAGES-1];
    assign sticky_nan_o = sticky_nan_q;
    assign sticky_inf_o = sticky_inf_q;

endmodule

// File: tb/tb_fp_mul_lane_pipe.sv
// Scoreboard bench for fp_mul_lane_pipe: FP16 x4 lanes / 2 stages and BF16 x1 lane / 4 stages,
// checked against an integer-arithmetic model of the multiply rules.
`timescale 1ns/1ps
module tb_fp_mul_lane_pipe;

    localparam int AS = 2;
    localparam int BS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_clr = 1'b0;
    logic [63:0] a_in_a = '0, a_in_b = '0;
    logic [3:0]  a_mask = '0;
    logic [87:0] a_prod;
    logic [23:0] a_exp;
    logic [3:0]  a_sign, a_zero, a_inf, a_nan;
    logic        a_snan, a_sinf;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_clr = 1'b0;
    logic [15:0] b_in_a = '0, b_in_b = '0;
    logic [0:0]  b_mask = '0;
    logic [15:0] b_prod;
    logic [8:0]  b_exp;
    logic [0:0]  b_sign, b_zero, b_inf, b_nan;
    logic        b_snan, b_sinf;

    fp_mul_lane_pipe #(.EWIDTH(5), .MWIDTH(10), .LANES(4), .STAGES(AS)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_a_i(a_in_a), .in_b_i(a_in_b), .in_mask_i(a_mask), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_prod_o(a_prod), .out_exp_o(a_exp), .out_sign_o(a_sign),
        .out_zero_o(a_zero), .out_inf_o(a_inf), .out_nan_o(a_nan), .sticky_nan_o(a_snan),
        .sticky_inf_o(a_sinf), .clr_sticky_i(a_clr));

    fp_mul_lane_pipe #(.EWIDTH(8), .MWIDTH(7), .LANES(1), .STAGES(BS)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_a_i(b_in_a), .in_b_i(b_in_b), .in_mask_i(b_mask), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .out_prod_o(b_prod), .out_exp_o(b_exp), .out_sign_o(b_sign),
        .out_zero_o(b_zero), .out_inf_o(b_inf), .out_nan_o(b_nan), .sticky_nan_o(b_snan),
        .sticky_inf_o(b_sinf), .clr_sticky_i(b_clr));

    typedef struct {
        logic [87:0] prod;
        logic [23:0] ex;
        logic [3:0]  sign, zero, inf, nan;
        int          acc;
        int          snap;
    } bundle_t;

    bundle_t qa[$], qb[$];
    int n_chk = 0, n_fail = 0, cyc = 0, stall_a = 0, stall_b = 0;
    logic sn_a = 0, si_a = 0, sn_b = 0, si_b = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decode each lane with plain integer arithmetic from the format rules.
    function automatic bundle_t model(input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] mask, input int ew, input int mw,
                                      input int lanes);
        bundle_t r;
        int dw, pw, exw, bias, emax, mmax;
        r = '{default: '0};
        dw = 1 + ew + mw; pw = 2 * mw + 2; exw = ew + 1;
        bias = (1 << (ew - 1)) - 1; emax = (1 << ew) - 1; mmax = (1 << mw) - 1;
        for (int l = 0; l < lanes; l++) begin
            int oa, ob, ea, eb, ma, mb, siga, sigb, xa, xb, p;
            bit na, nb, ia, ib, za, zb, nan, inf, sa, sb;
            oa = int'((a >> (l * dw)) & 64'((1 << dw) - 1));
            ob = int'((b >> (l * dw)) & 64'((1 << dw) - 1));
            ea = (oa >> mw) & emax; ma = oa & mmax; sa = ((oa >> (ew + mw)) & 1) != 0;
            eb = (ob >> mw) & emax; mb = ob & mmax; sb = ((ob >> (ew + mw)) & 1) != 0;
            na = (ea == emax) && (ma != 0); ia = (ea == emax) && (ma == 0); za = (ea == 0) && (ma == 0);
            nb = (eb == emax) && (mb != 0); ib = (eb == emax) && (mb == 0); zb = (eb == 0) && (mb == 0);
            siga = ((ea != 0) ? (1 << mw) : 0) + ma;
            sigb = ((eb != 0) ? (1 << mw) : 0) + mb;
            xa = (ea != 0) ? ea - bias : 1 - bias;
            xb = (eb != 0) ? eb - bias : 1 - bias;
            nan = na || nb || (ia && zb) || (ib && za);
            inf = (ia || ib) && !nan;
            if (mask[l]) begin
                r.sign[l] = sa ^ sb;
                r.nan[l]  = nan;
                r.inf[l]  = inf;
                if (!nan && !inf) begin
                    p = siga * sigb;
                    r.prod |= 88'(p) << (l * pw);
                    r.ex   |= 24'((xa + xb) & ((1 << exw) - 1)) << (l * exw);
                    r.zero[l] = (p == 0);
                end
            end
        end
        return r;
    endfunction

    function automatic int rand_op(input int ew, input int mw);
        int k, e, m, s, emax;
        emax = (1 << ew) - 1;
        k = int'($urandom_range(0, 9));
        s = int'($urandom_range(0, 1));
        m = int'($urandom) & ((1 << mw) - 1);
        case (k)
            0: begin e = 0; m = 0; end
            1: begin e = emax; m = 0; end
            2: begin e = emax; m = m | 1; end
            3: e = 0;
            default: e = int'($urandom_range(1, emax - 1));
        endcase
        return (s << (ew + mw)) | (e << mw) | m;
    endfunction

    function automatic logic [63:0] rand_a_bundle();
        logic [63:0] v;
        for (int l = 0; l < 4; l++) v[l*16 +: 16] = 16'(rand_op(5, 10));
        return v;
    endfunction

    task automatic cmp(input string t, input bundle_t e, input logic [87:0] p, input logic [23:0] x,
                       input logic [3:0] sg, input logic [3:0] z, input logic [3:0] i, input logic [3:0] n);
        check({t, "_prod"}, p, e.prod);
        check({t, "_exp"},  x, e.ex);
        check({t, "_sign"}, sg, e.sign);
        check({t, "_zero"}, z, e.zero);
        check({t, "_inf"},  i, e.inf);
        check({t, "_nan"},  n, e.nan);
    endtask

    task automatic drive_a(input logic v, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] mask, input logic ordy, input logic clr,
                           output logic acc, output logic rdy);
        bundle_t e;
        @(negedge clk);
        a_in_valid = v; a_in_a = a; a_in_b = b; a_mask = mask; a_out_ready = ordy; a_clr = clr;
        #1;
        rdy = a_in_ready;
        acc = v && a_in_ready;
        if (acc) begin
            e = model(a, b, mask, 5, 10, 4);
            e.acc = cyc;
            e.snap = stall_a + ((a_out_valid && !a_out_ready) ? 1 : 0);
            qa.push_back(e);
        end
    endtask

    task automatic drive_b(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic mask, input logic ordy, input logic clr, output logic acc);
        bundle_t e;
        @(negedge clk);
        b_in_valid = v; b_in_a = a; b_in_b = b; b_mask = mask; b_out_ready = ordy; b_clr = clr;
        #1;
        acc = v && b_in_ready;
        if (acc) begin
            e = model({48'd0, a}, {48'd0, b}, {3'd0, mask}, 8, 7, 1);
            e.acc = cyc;
            e.snap = stall_b + ((b_out_valid && !b_out_ready) ? 1 : 0);
            qb.push_back(e);
        end
    endtask

    task automatic send_a(input logic [63:0] a, input logic [63:0] b, input logic [3:0] mask);
        logic acc, rdy;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive_a(1'b1, a, b, mask, 1'b1, 1'b0, acc, rdy);
        check("a_send_accept", acc, 1'b1);
    endtask

    task automatic drain_a();
        logic acc, rdy;
        for (int i = 0; i < 40 && qa.size() != 0; i++) drive_a(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, rdy);
        check("a_drain", qa.size(), 0);
    endtask

    task automatic drain_b();
        logic acc;
        for (int i = 0; i < 40 && qb.size() != 0; i++) drive_b(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        check("b_drain", qb.size(), 0);
    endtask

    // Monitor A: scoreboard pop, latency, hold stability under stall, sticky model.
    logic        ha_v = 0;
    logic [87:0] ha_p;
    logic [23:0] ha_x;
    logic [15:0] ha_f;
    always @(negedge clk) begin
        bundle_t e;
        #2;
        if (!rst_n) begin
            sn_a = 0; si_a = 0; ha_v = 0;
        end else begin
            check("a_sticky_nan", a_snan, sn_a);
            check("a_sticky_inf", a_sinf, si_a);
            if (ha_v) begin
                check("a_hold_valid", a_out_valid, 1'b1);
                check("a_hold_prod", a_prod, ha_p);
                check("a_hold_exp", a_exp, ha_x);
                check("a_hold_flags", {a_sign, a_zero, a_inf, a_nan}, ha_f);
            end
            ha_v = 0;
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("a_unexpected_output", a_out_valid, 1'b0);
                else begin
                    e = qa.pop_front();
                    cmp("a", e, a_prod, a_exp, a_sign, a_zero, a_inf, a_nan);
                    if (stall_a == e.snap) check("a_latency", cyc - e.acc, AS);
                    sn_a = sn_a | (|e.nan);
                    si_a = si_a | (|e.inf);
                end
            end else if (a_out_valid) begin
                stall_a++;
                ha_v = 1; ha_p = a_prod; ha_x = a_exp; ha_f = {a_sign, a_zero, a_inf, a_nan};
            end
            if (a_clr) begin sn_a = 0; si_a = 0; end
        end
    end

    always @(negedge clk) begin
        bundle_t e;
        #2;
        if (!rst_n) begin
            sn_b = 0; si_b = 0;
        end else begin
            check("b_sticky_nan", b_snan, sn_b);
            check("b_sticky_inf", b_sinf, si_b);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) check("b_unexpected_output", b_out_valid, 1'b0);
                else begin
                    e = qb.pop_front();
                    cmp("b", e, {72'd0, b_prod}, {15'd0, b_exp}, {3'd0, b_sign}, {3'd0, b_zero},
                        {3'd0, b_inf}, {3'd0, b_nan});
                    if (stall_b == e.snap) check("b_latency", cyc - e.acc, BS);
                    sn_b = sn_b | (|e.nan);
                    si_b = si_b | (|e.inf);
                end
            end else if (b_out_valid) stall_b++;
            if (b_clr) begin sn_b = 0; si_b = 0; end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [15:0] dir_a [10] = '{16'h3C00, 16'hBE00, 16'h0001, 16'h0000, 16'h7C00,
                                16'h7C00, 16'h7E00, 16'hFC00, 16'h0400, 16'h7BFF};
    logic [15:0] dir_b [10] = '{16'h4000, 16'h4000, 16'h3C00, 16'h3C00, 16'h0000,
                                16'h3C00, 16'h3C00, 16'h7C00, 16'h8400, 16'hFBFF};

    initial begin
        logic acc, rdy, acc2;
        logic [63:0] ra, rb;
        int sent, t;

        repeat (2) @(negedge clk);
        #1;
        check("a_rst_out_valid", a_out_valid, 1'b0);
        check("a_rst_in_ready", a_in_ready, 1'b1);
        check("a_rst_prod", a_prod, '0);
        check("a_rst_exp", a_exp, '0);
        check("a_rst_flags", {a_sign, a_zero, a_inf, a_nan, a_snan, a_sinf}, '0);
        check("b_rst_out_valid", b_out_valid, 1'b0);
        check("b_rst_in_ready", b_in_ready, 1'b1);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Directed FP16 vectors on lane 0, random operands on the other lanes.
        for (int i = 0; i < 10; i++) begin
            ra = rand_a_bundle(); rb = rand_a_bundle();
            ra[15:0] = dir_a[i]; rb[15:0] = dir_b[i];
            send_a(ra, rb, 4'hF);
        end
        drain_a();

        // Clear racing a NaN transfer: clear wins.
        send_a({48'd0, 16'h7C00}, {48'd0, 16'h0000}, 4'h1);
        for (int i = 0; i < 10 && !a_out_valid; i++) drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0, acc, rdy);
        check("a_nan_pending", a_out_valid, 1'b1);
        drive_a(1'b0, '0, '0, '0, 1'b1, 1'b1, acc, rdy);
        drive_a(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, rdy);
        check("a_clr_priority", a_snan, 1'b0);
        // NaN on a masked lane contributes nothing.
        send_a({48'h3C00_3C00_3C00, 16'h7E00}, {48'h4000_4000_4000, 16'h3C00}, 4'hE);
        drain_a();

        // Stream of 8 with output stalled on cycles 3..6.
        sent = 0;
        for (t = 1; t < 40 && sent < 8; t++) begin
            ra = rand_a_bundle(); rb = rand_a_bundle();
            drive_a(1'b1, ra, rb, 4'($urandom), !(t >= 3 && t <= 6), 1'b0, acc, rdy);
            if (t >= 4 && t <= 6) check("a_full_in_ready", rdy, 1'b0);
            if (t >= 7) check("a_stream_rate", acc, 1'b1);
            if (acc) sent++;
        end
        check("a_stream_sent", sent, 8);
        drain_a();

        for (int i = 0; i < 400; i++) begin
            drive_a($urandom_range(0, 3) != 0, rand_a_bundle(), rand_a_bundle(), 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc, rdy);
        end
        drain_a();

        send_b_dir: begin
            drive_b(1'b1, 16'h3F80, 16'h4000, 1'b1, 1'b1, 1'b0, acc);
            check("b_accept", acc, 1'b1);
            drive_b(1'b1, 16'h7F80, 16'h0000, 1'b1, 1'b1, 1'b0, acc);
            drive_b(1'b1, 16'h0001, 16'hBF80, 1'b1, 1'b1, 1'b0, acc);
        end
        for (int i = 0; i < 200; i++) begin
            drive_b($urandom_range(0, 3) != 0, 16'(rand_op(8, 7)), 16'(rand_op(8, 7)), 1'($urandom),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0, acc);
        end
        drain_b();

        // Reset with bundles in flight in both instances.
        fork
            drive_a(1'b1, rand_a_bundle(), rand_a_bundle(), 4'hF, 1'b1, 1'b0, acc, rdy);
            drive_b(1'b1, 16'h3F80, 16'h4000, 1'b1, 1'b1, 1'b0, acc2);
        join
        fork
            drive_a(1'b1, rand_a_bundle(), rand_a_bundle(), 4'hF, 1'b0, 1'b0, acc, rdy);
            drive_b(1'b1, 16'h7F80, 16'h3F80, 1'b1, 1'b0, 1'b0, acc2);
        join
        fork
            drive_a(1'b0, '0, '0, '0, 1'b0, 1'b0, acc, rdy);
            drive_b(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc2);
        join
        #2;
        check("a_pre_reset_valid", a_out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("a_reset_out_valid", a_out_valid, 1'b0);
        check("a_reset_in_ready", a_in_ready, 1'b1);
        check("a_reset_prod", a_prod, '0);
        check("a_reset_flags", {a_nan, a_inf, a_snan, a_sinf}, '0);
        check("b_reset_out_valid", b_out_valid, 1'b0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fork
                drive_a(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, rdy);
                drive_b(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc2);
            join
            check("a_post_reset_idle", a_out_valid, 1'b0);
            check("b_post_reset_idle", b_out_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
